// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, round-constant table and key-expansion FSM state type
package aes_pkg;

    localparam int AES_NR          = 10;
    localparam int AES_BLOCK_WIDTH = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } ke_state_t;

    // Round constant for expansion round r (1..10); zero outside that range.
    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - combinational AES forward S-box, shared by SubWord and subBytes
module sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Byte x lives at bits [8*x +: 8] of the ascending-range table.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign result = SBOX_TABLE[{value, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 round-key generator, one round key per accepted cycle
module key_expansion
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH  = 128,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_expansion_valid_in,
    input  logic [KEY_WIDTH-1:0]  key_expansion_key_in,
    output logic                  key_expansion_ready_out,
    input  logic                  key_expansion_ready_in,
    output logic [DATA_WIDTH-1:0] key_expansion_round_key_out,
    output logic [3:0]            key_expansion_round_out,
    output logic                  key_expansion_valid_out,
    output logic                  key_expansion_done_out
);

    localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

    ke_state_t             state_q, state_d;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [3:0]            round_q;
    logic                  load, advance;

    logic [31:0]           rot_word, sub_word;
    logic [31:0]           w0_next, w1_next, w2_next, w3_next;

    assign rot_word = {key_q[23:0], key_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        sbox u_sbox (
            .value  (rot_word[8*i +: 8]),
            .result (sub_word[8*i +: 8])
        );
    end

    assign w0_next = key_q[127:96] ^ sub_word ^ {get_rcon(round_q + 4'd1), 24'h0};
    assign w1_next = key_q[95:64]  ^ w0_next;
    assign w2_next = key_q[63:32]  ^ w1_next;
    assign w3_next = key_q[31:0]   ^ w2_next;

    always_comb begin
        state_d                 = state_q;
        load                    = 1'b0;
        advance                 = 1'b0;
        key_expansion_ready_out = 1'b0;
        key_expansion_valid_out = 1'b0;
        key_expansion_done_out  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_expansion_ready_out = 1'b1;
                if (key_expansion_valid_in) begin
                    load    = 1'b1;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                key_expansion_valid_out = 1'b1;
                // A key offered while busy is dropped, even on the final handshake.
                if (key_expansion_ready_in) begin
                    if (round_q == LAST_ROUND) begin
                        key_expansion_done_out = 1'b1;
                        state_d                = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                key_q   <= key_expansion_key_in;
                round_q <= 4'd0;
            end else if (advance) begin
                key_q   <= {w0_next, w1_next, w2_next, w3_next};
                round_q <= round_q + 4'd1;
            end
        end
    end

    assign key_expansion_round_key_out = key_expansion_valid_out ? key_q   : '0;
    assign key_expansion_round_out     = key_expansion_valid_out ? round_q : 4'd0;

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - scoreboard bench for key_expansion with FIPS-197 directed vectors
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [127:0] key_in;
    logic         ready_out;
    logic         ready_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         valid_out;
    logic         done_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        bit           check_key;
        bit           done;
    } exp_t;

    exp_t sb[$];

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] DATA  = 128'h54776f204f6e65204e696e652054776f;

    logic [127:0] exp_a [0:10];
    logic [127:0] exp_b [0:10];

    key_expansion dut (
        .clk                         (clk),
        .rst                         (rst),
        .key_expansion_valid_in      (valid_in),
        .key_expansion_key_in        (key_in),
        .key_expansion_ready_out     (ready_out),
        .key_expansion_ready_in      (ready_in),
        .key_expansion_round_key_out (round_key),
        .key_expansion_round_out     (round_idx),
        .key_expansion_valid_out     (valid_out),
        .key_expansion_done_out      (done_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted round key is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", {124'h0, round_idx}, 128'hffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("round_idx", {124'h0, round_idx}, {124'h0, e.round});
                if (e.check_key) check($sformatf("round_key_r%0d", e.round), round_key, e.key);
                check($sformatf("done_r%0d", e.round), {127'h0, done_out}, {127'h0, e.done});
            end
        end
    end

    task automatic push_run(input bit use_b);
        exp_t e;
        for (int r = 0; r <= 10; r++) begin
            e.round     = 4'(r);
            e.key       = use_b ? exp_b[r] : exp_a[r];
            e.check_key = use_b ? (r == 0 || r == 1 || r == 10) : 1'b1;
            e.done      = (r == 10);
            sb.push_back(e);
        end
    endtask

    task automatic start_load(input logic [127:0] k);
        @(posedge clk); #1;
        valid_in = 1'b1;
        key_in   = k;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_round(input int r);
        int i;
        for (i = 0; i < 40; i++) begin
            if (valid_out && round_idx == 4'(r)) break;
            @(posedge clk); #1;
        end
        if (i == 40) check("wait_round_timeout", 128'h0, 128'h1);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_out) break;
        end
        if (i == 40) check("wait_done_timeout", 128'h0, 128'h1);
        @(negedge clk);
        check("ready_after_done", {127'h0, ready_out}, 128'h1);
        check("valid_after_done", {127'h0, valid_out}, 128'h0);
    endtask

    initial begin
        exp_a[0]  = KEY_A;
        exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int r = 0; r <= 10; r++) exp_b[r] = 128'h0;
        exp_b[0]  = KEY_B;
        exp_b[1]  = 128'he232fcf191129188b159e4e6d679a293;
        exp_b[10] = 128'h28fddef86da4244accc0a4fe3b316f26;

        rst      = 1'b1;
        valid_in = 1'b0;
        key_in   = '0;
        ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {127'h0, ready_out}, 128'h1);
        check("reset_valid", {127'h0, valid_out}, 128'h0);
        check("reset_key",   round_key, 128'h0);
        check("reset_round", {124'h0, round_idx}, 128'h0);
        check("reset_done",  {127'h0, done_out}, 128'h0);

        // Full expansion of key A with ready_in held high.
        push_run(1'b0);
        start_load(KEY_A);
        @(negedge clk);
        check("busy_ready_r0", {127'h0, ready_out}, 128'h0);
        wait_done();

        // Key B, addRoundKey on round 0, and a new key offered on the final handshake.
        push_run(1'b1);
        start_load(KEY_B);
        @(negedge clk);
        check("add_round_key_r0", round_key ^ DATA, 128'h001f0e543c4e08596e221b0b4774311a);
        @(posedge clk); #1;
        wait_round(10);
        valid_in = 1'b1;
        key_in   = KEY_A;
        @(negedge clk);
        check("final_hs_ready", {127'h0, ready_out}, 128'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_gap_valid", {127'h0, valid_out}, 128'h0);
        check("idle_gap_ready", {127'h0, ready_out}, 128'h1);
        push_run(1'b0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        wait_done();

        // Stall five cycles at round 3.
        push_run(1'b0);
        start_load(KEY_A);
        wait_round(3);
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_round", {124'h0, round_idx}, 128'h3);
            check("stall_key", round_key, exp_a[3]);
            check("stall_valid", {127'h0, valid_out}, 128'h1);
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        wait_done();

        // Different key offered while busy at round 4 must be ignored.
        push_run(1'b0);
        start_load(KEY_A);
        wait_round(4);
        valid_in = 1'b1;
        key_in   = KEY_B;
        @(negedge clk);
        check("busy_ready_r4", {127'h0, ready_out}, 128'h0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        wait_done();

        // Reset at round 6 abandons the expansion.
        push_run(1'b0);
        start_load(KEY_A);
        wait_round(6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", {127'h0, valid_out}, 128'h0);
        check("midrst_key",   round_key, 128'h0);
        check("midrst_round", {124'h0, round_idx}, 128'h0);
        check("midrst_done",  {127'h0, done_out}, 128'h0);
        check("midrst_ready", {127'h0, ready_out}, 128'h1);
        sb.delete();
        push_run(1'b0);
        start_load(KEY_A);
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
